fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory's 16-bit pointer.
- Captures the returned instr_out into an instruction register (IF/ID latch) for the decoder.
- Handles sequential advance, stall, absolute jump, PC-relative branch and halt.

---
 rtl/fetch_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the memory pointer and
// latches the returned instruction into the IF/ID instruction register.
module fetch_unit #(
   parameter int                   ADDR_W   = 16,
   parameter int                   INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC = 16'h0000,
   parameter int                   PC_STEP  = 2,
   parameter logic [INSTR_W-1:0]   HALT_OP  = 16'hFFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               stall,
   input  logic               jump_en,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_off,
   output logic [ADDR_W-1:0]  pointer,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   output logic               halted,
   output logic               misalign,
   output logic [15:0]        fetch_count
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t               r_state;
   logic [ADDR_W-1:0]    r_pc;
   logic [INSTR_W-1:0]   r_ir;
   logic [ADDR_W-1:0]    r_ir_pc;
   logic                 r_ir_valid;
   logic                 r_halted;
   logic                 r_misalign;
   logic [15:0]          r_fetch_count;

   logic [ADDR_W-1:0]    w_br_tgt;
   logic [ADDR_W-1:0]    w_pc_next;
   logic                 w_is_halt;

   // branch target is relative to the instruction currently in ir
   assign w_br_tgt  = r_ir_pc + branch_off;
   assign w_pc_next = r_pc + ADDR_W'(PC_STEP);
   assign w_is_halt = (instr_in == HALT_OP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= RUN;
         r_pc          <= RESET_PC;
         r_ir          <= '0;
         r_ir_pc       <= '0;
         r_ir_valid    <= 1'b0;
         r_halted      <= 1'b0;
         r_misalign    <= 1'b0;
         r_fetch_count <= '0;
      end else if (jump_en) begin
         r_pc       <= {jump_addr[ADDR_W-1:1], 1'b0};
         r_ir_valid <= 1'b0;
         r_state    <= RUN;
         r_halted   <= 1'b0;
         r_misalign <= r_misalign | jump_addr[0];
      end else if (branch_en && r_state == RUN) begin
         r_pc       <= {w_br_tgt[ADDR_W-1:1], 1'b0};
         r_ir_valid <= 1'b0;
         r_misalign <= r_misalign | w_br_tgt[0];
      end else if (r_state == HALTED) begin
         r_ir_valid <= 1'b0;
      end else if (!stall) begin
         r_ir          <= instr_in;
         r_ir_pc       <= r_pc;
         r_ir_valid    <= 1'b1;
         r_fetch_count <= r_fetch_count + 16'd1;
         if (w_is_halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
         end else begin
            r_pc <= w_pc_next;
         end
      end
   end

   assign pointer     = r_pc;
   assign ir          = r_ir;
   assign ir_pc       = r_ir_pc;
   assign ir_valid    = r_ir_valid;
   assign halted      = r_halted;
   assign misalign    = r_misalign;
   assign fetch_count = r_fetch_count;

endmodule
